// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl: multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB) driving regfile, ALU, memory and PC control.
module mips_mc_ctrl #(
  parameter int WAIT_MAX    = 255,
  parameter bit ALLOW_R0_WB = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  input  logic        alu_zero,
  input  logic        mem_done,
  output logic [4:0]  reg_j,
  output logic [4:0]  reg_k,
  output logic [4:0]  reg_i,
  output logic        w_enable,
  output logic        wb_sel,
  output logic [2:0]  alu_op,
  output logic        alu_src_imm,
  output logic [31:0] imm32,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        illegal
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;
  state_t state, state_nx;
  logic [31:0] ir;
  logic [7:0] cnt, cnt_nx;
  logic [5:0] op, funct;
  logic r_type, r_ok, is_addi, is_lw, is_sw, is_beq, is_j, legal, timeout;
  assign op      = ir[31:26];
  assign funct   = ir[5:0];
  assign r_type  = op == 6'h00;
  assign r_ok    = r_type && (funct == 6'h20 || funct == 6'h22 || funct == 6'h24 || funct == 6'h25 || funct == 6'h2A);
  assign is_addi = op == 6'h08;
  assign is_lw   = op == 6'h23;
  assign is_sw   = op == 6'h2B;
  assign is_beq  = op == 6'h04;
  assign is_j    = op == 6'h02;
  assign legal   = r_ok || is_addi || is_lw || is_sw || is_beq || is_j;
  // Last permitted MEM cycle: the counter holds the number of MEM cycles already spent.
  assign timeout = cnt == 8'(WAIT_MAX - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
      ir    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (state == FETCH && instr_valid) ir <= instr;
    end
  end
  always_comb begin
    state_nx = state;
    cnt_nx   = '0;
    case (state)
      FETCH:   state_nx = instr_valid ? DECODE : FETCH;
      DECODE:  state_nx = (is_j || !legal) ? FETCH : EXEC;
      EXEC:    state_nx = is_beq ? FETCH : (is_lw || is_sw) ? MEM : WB;
      MEM: begin
        state_nx = mem_done ? (is_lw ? WB : FETCH) : timeout ? FETCH : MEM;
        cnt_nx   = (mem_done || timeout) ? 8'd0 : cnt + 8'd1;
      end
      WB:      state_nx = FETCH;
      default: state_nx = FETCH;
    endcase
    instr_ready = state == FETCH;
    reg_j       = ir[25:21];
    reg_k       = ir[20:16];
    reg_i       = r_type ? ir[15:11] : ir[20:16];
    imm32       = {{16{ir[15]}}, ir[15:0]};
    alu_op      = ((r_type && funct == 6'h22) || is_beq) ? 3'd1 :
                  (r_type && funct == 6'h24) ? 3'd2 :
                  (r_type && funct == 6'h25) ? 3'd3 :
                  (r_type && funct == 6'h2A) ? 3'd4 : 3'd0;
    alu_src_imm = is_addi || is_lw || is_sw;
    mem_rd      = state == MEM && is_lw;
    mem_wr      = state == MEM && is_sw;
    w_enable    = state == WB && (reg_i != 5'd0 || ALLOW_R0_WB);
    wb_sel      = state == WB && is_lw;
    pc_we       = (state == FETCH && instr_valid) || (state == DECODE && is_j) || (state == EXEC && is_beq && alu_zero);
    pc_src      = (state == DECODE && is_j) ? 2'd2 : (state == EXEC && is_beq) ? 2'd1 : 2'd0;
    illegal     = (state == DECODE && !legal) || (state == MEM && !mem_done && timeout);
  end
endmodule

// File: tb/tb_mips_mc_ctrl.sv
// tb_mips_mc_ctrl: table-driven directed checks of mips_mc_ctrl plus hand-written reset/timeout sequences.
module tb_mips_mc_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, instr_valid = 1'b0, alu_zero = 1'b0, mem_done = 1'b0;
  logic [31:0] instr = '0;
  logic instr_ready, w_enable, wb_sel, alu_src_imm, mem_rd, mem_wr, pc_we, illegal;
  logic [4:0] reg_j, reg_k, reg_i;
  logic [2:0] alu_op;
  logic [31:0] imm32;
  logic [1:0] pc_src;
  int n_cmp = 0, n_bad = 0;

  mips_mc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .alu_zero(alu_zero), .mem_done(mem_done), .reg_j(reg_j), .reg_k(reg_k),
    .reg_i(reg_i), .w_enable(w_enable), .wb_sel(wb_sel), .alu_op(alu_op),
    .alu_src_imm(alu_src_imm), .imm32(imm32), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .pc_we(pc_we), .pc_src(pc_src), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    bit          az;
    bit          hold;
    int          extra;
    int          lat;
    int          rj, rk, aop, aimm;
    logic [31:0] imm;
    int          nwe, wi, ws, nill, nrd, nwr, pcw, psrc;
  } vec_t;

  vec_t v[16];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic run(input vec_t x, input int idx);
    int cyc, nwe, wi, ws, nill, nrd, nwr, pcw, psrc, both, mcnt;
    string t;
    t = $sformatf("v%0d", idx);
    {nwe, wi, ws, nill, nrd, nwr, pcw, psrc, both, mcnt} = '0;
    @(negedge clk);
    instr = x.instr; alu_zero = x.az; instr_valid = 1'b1;
    #1;
    chk({t, " hs_ready"}, 64'(instr_ready), 64'd1);
    chk({t, " hs_pc"}, 64'({pc_we, pc_src}), 64'b100);
    @(negedge clk);
    if (x.hold) instr = ~x.instr; else instr_valid = 1'b0;
    chk({t, " reg_j"}, 64'(reg_j), 64'(x.rj));
    chk({t, " reg_k"}, 64'(reg_k), 64'(x.rk));
    chk({t, " alu_op"}, 64'(alu_op), 64'(x.aop));
    chk({t, " alu_src_imm"}, 64'(alu_src_imm), 64'(x.aimm));
    chk({t, " imm32"}, 64'(imm32), 64'(x.imm));
    cyc = 1;
    while (!instr_ready && cyc < 400) begin
      if (w_enable) begin nwe++; wi = int'(reg_i); ws = int'(wb_sel); end
      if (illegal) nill++;
      if (mem_rd) nrd++;
      if (mem_wr) nwr++;
      if (mem_rd && mem_wr) both++;
      if (pc_we) begin pcw++; psrc = int'(pc_src); end
      mem_done = (mem_rd || mem_wr) && mcnt == x.extra;
      if (mem_rd || mem_wr) mcnt++;
      @(negedge clk);
      cyc++;
    end
    instr_valid = 1'b0; mem_done = 1'b0;
    chk({t, " latency"}, 64'(cyc), 64'(x.lat));
    chk({t, " w_enable_cycles"}, 64'(nwe), 64'(x.nwe));
    if (x.nwe > 0) begin
      chk({t, " wb_reg_i"}, 64'(wi), 64'(x.wi));
      chk({t, " wb_sel"}, 64'(ws), 64'(x.ws));
    end
    chk({t, " illegal_pulses"}, 64'(nill), 64'(x.nill));
    chk({t, " mem_rd_cycles"}, 64'(nrd), 64'(x.nrd));
    chk({t, " mem_wr_cycles"}, 64'(nwr), 64'(x.nwr));
    chk({t, " rd_wr_overlap"}, 64'(both), 64'd0);
    chk({t, " pc_we_cycles"}, 64'(pcw), 64'(x.pcw));
    chk({t, " pc_src"}, 64'(psrc), 64'(x.psrc));
  endtask

  initial begin
    //            instr         az hold extra lat rj rk aop aimm imm           nwe wi ws nill nrd nwr pcw psrc
    v[0]  = '{32'h00221820, 0, 1, 0,    4,   1, 2, 0, 0, 32'h00001820, 1, 3, 0, 0, 0, 0,   0, 0};
    v[1]  = '{32'h8C850008, 0, 0, 2,    7,   4, 5, 0, 1, 32'h00000008, 1, 5, 1, 0, 3, 0,   0, 0};
    v[2]  = '{32'h10210003, 1, 0, 0,    3,   1, 1, 1, 0, 32'h00000003, 0, 0, 0, 0, 0, 0,   1, 1};
    v[3]  = '{32'h10210003, 0, 0, 0,    3,   1, 1, 1, 0, 32'h00000003, 0, 0, 0, 0, 0, 0,   0, 0};
    v[4]  = '{32'hFC000000, 0, 0, 0,    2,   0, 0, 0, 0, 32'h00000000, 0, 0, 0, 1, 0, 0,   0, 0};
    v[5]  = '{32'h20000001, 0, 0, 0,    4,   0, 0, 0, 1, 32'h00000001, 0, 0, 0, 0, 0, 0,   0, 0};
    v[6]  = '{32'h01093822, 0, 0, 0,    4,   8, 9, 1, 0, 32'h00003822, 1, 7, 0, 0, 0, 0,   0, 0};
    v[7]  = '{32'h0022502A, 0, 0, 0,    4,   1, 2, 4, 0, 32'h0000502A, 1, 10, 0, 0, 0, 0,  0, 0};
    v[8]  = '{32'h00A62024, 0, 0, 0,    4,   5, 6, 2, 0, 32'h00002024, 1, 4, 0, 0, 0, 0,   0, 0};
    v[9]  = '{32'h018D5825, 0, 0, 0,    4,   12, 13, 3, 0, 32'h00005825, 1, 11, 0, 0, 0, 0, 0, 0};
    v[10] = '{32'h2062FFFC, 0, 0, 0,    4,   3, 2, 0, 1, 32'hFFFFFFFC, 1, 2, 0, 0, 0, 0,   0, 0};
    v[11] = '{32'h08000010, 0, 0, 0,    2,   0, 0, 0, 0, 32'h00000010, 0, 0, 0, 0, 0, 0,   1, 2};
    v[12] = '{32'hACE60004, 0, 0, 0,    4,   7, 6, 0, 1, 32'h00000004, 0, 0, 0, 0, 0, 1,   0, 0};
    v[13] = '{32'h00221821, 0, 0, 0,    2,   1, 2, 0, 0, 32'h00001821, 0, 0, 0, 1, 0, 0,   0, 0};
    v[14] = '{32'hACE60004, 0, 0, 1000, 258, 7, 6, 0, 1, 32'h00000004, 0, 0, 0, 1, 0, 255, 0, 0};
    v[15] = '{32'h8C850008, 0, 0, 0,    5,   4, 5, 0, 1, 32'h00000008, 1, 5, 1, 0, 1, 0,   0, 0};
    #1;
    chk("reset instr_ready", 64'(instr_ready), 64'd1);
    chk("reset outputs", {5'd0, reg_j, reg_k, reg_i, w_enable, wb_sel, alu_op, alu_src_imm, imm32,
                          mem_rd, mem_wr, pc_we, pc_src, illegal}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("idle instr_ready", 64'(instr_ready), 64'd1);
    mem_done = 1'b1;
    @(negedge clk);
    mem_done = 1'b0;
    chk("stray mem_done", 64'({instr_ready, illegal, w_enable}), 64'b100);
    for (int i = 0; i < 16; i++) run(v[i], i);
    // Reset landing in the middle of a load's MEM phase.
    @(negedge clk);
    instr = 32'h8C850008; instr_valid = 1'b1;
    @(negedge clk); instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid mem_rd before reset", 64'(mem_rd), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid reset mem_rd", 64'(mem_rd), 64'd0);
    chk("mid reset ready", 64'(instr_ready), 64'd1);
    chk("mid reset ir cleared", 64'({reg_k, w_enable}), 64'd0);
    @(negedge clk); rst_n = 1'b1; mem_done = 1'b1;
    @(negedge clk); mem_done = 1'b0;
    chk("after reset no write", 64'({w_enable, mem_rd, instr_ready}), 64'b001);
    @(negedge clk);
    chk("after reset idle", 64'({w_enable, illegal, instr_ready}), 64'b001);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
